// File: rtl/dma_copy_engine.sv
// -----------------------------------------------------------------------------
// dma_copy_engine
//
// Single-port memory copy engine. A transfer copies `length` words from
// src_addr upward to dst_addr upward. Each word takes one READ cycle and one
// WRITE cycle. All outputs are decoded from registered state only (Moore).
//
// Optional feature (compile-time macro DMA_COPY_ENGINE_FILL_EN):
//   When defined, fill_mode is latched at start. If it is set, the READ phase
//   is skipped and every WRITE stores fill_value (one cycle per word).
//   When undefined, fill_mode and fill_value are accepted but ignored.
//
// Ports:
//   clock            in   single clock, all state changes on posedge
//   reset            in   asynchronous active-high reset
//   start            in   one-cycle transfer request, sampled only in IDLE
//   src_addr         in   first source word address
//   dst_addr         in   first destination word address
//   length           in   number of words to move (0 is legal)
//   fill_mode        in   1 = write fill_value instead of copying (option)
//   fill_value       in   constant word used in fill mode (option)
//   mem_address      out  memory port address (0 in IDLE/DONE)
//   mem_write_data   out  memory port write data (0 outside WRITE)
//   mem_write_enable out  memory port write strobe
//   mem_read_data    in   memory port read data (memory updates it on negedge)
//   busy             out  high in READ and WRITE
//   done             out  one-cycle completion pulse
//   words_done       out  words written in the current/last transfer
// -----------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  fill_mode,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q,   src_d;
  logic [ADDR_WIDTH-1:0] dst_q,   dst_d;
  logic [ADDR_WIDTH-1:0] len_q,   len_d;
  logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] buf_q,   buf_d;
  logic                  fill_q,  fill_d;

  // Fill request as seen at start; tied off when the fill option is absent.
  logic                  fill_req_s;
`ifdef DMA_COPY_ENGINE_FILL_EN
  assign fill_req_s = fill_mode;
`else
  assign fill_req_s = 1'b0;
  // Fill inputs exist on the port list but have no function in this build.
  logic unused_fill_s;
  assign unused_fill_s = ^{fill_mode, fill_value};
`endif

  // State and transfer registers; async reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= {ADDR_WIDTH{1'b0}};
      dst_q   <= {ADDR_WIDTH{1'b0}};
      len_q   <= {ADDR_WIDTH{1'b0}};
      cnt_q   <= {ADDR_WIDTH{1'b0}};
      buf_q   <= {DATA_WIDTH{1'b0}};
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic: inputs are only looked at in IDLE, so mid-transfer
  // changes on start/src/dst/length/fill have no effect.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          cnt_d  = {ADDR_WIDTH{1'b0}};
          fill_d = fill_req_s;
          if (length == {ADDR_WIDTH{1'b0}}) begin
            state_d = S_DONE;
          end else if (fill_req_s) begin
            // Fill data rides in the data buffer so WRITE needs no mux.
            buf_d   = fill_value;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        buf_d   = mem_read_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_d == len_q) begin
          state_d = S_DONE;
        end else if (fill_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode; address sums wrap naturally at ADDR_WIDTH bits.
  always_comb begin
    mem_address      = {ADDR_WIDTH{1'b0}};
    mem_write_data   = {DATA_WIDTH{1'b0}};
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_READ: begin
        mem_address = src_q + cnt_q;
        busy        = 1'b1;
      end
      S_WRITE: begin
        mem_address      = dst_q + cnt_q;
        mem_write_data   = buf_q;
        mem_write_enable = 1'b1;
        busy             = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign words_done = cnt_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_engine
//
// Directed bench for dma_copy_engine with a behavioural single-port memory
// (registered read on negedge, write on posedge). Inputs are driven and
// outputs sampled on the negative clock edge.
// -----------------------------------------------------------------------------
module tb_dma_copy_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr, dst_addr, length;
  logic        fill_mode;
  logic [15:0] fill_value;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic [15:0] mem_read_data;
  logic        busy, done;
  logic [15:0] words_done;

  int vectors     = 0;
  int miscompares = 0;
  int wcount      = 0;

  logic [15:0] mem [0:65535];

  dma_copy_engine #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .fill_mode        (fill_mode),
    .fill_value       (fill_value),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .busy             (busy),
    .done             (done),
    .words_done       (words_done)
  );

  always #5 clock = ~clock;

  // Memory model: read registered on negedge, write on posedge.
  always @(negedge clock) mem_read_data <= mem[mem_address];

  always @(posedge clock) begin
    if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
      wcount <= wcount + 1;
    end
  end

  // Initial memory image.
  function automatic logic [15:0] orig(input logic [15:0] a);
    logic [15:0] r;
    r = a ^ 16'hA5A5;
    if (a == 16'h0010) r = 16'hA001;
    if (a == 16'h0011) r = 16'hB002;
    if (a == 16'h0012) r = 16'hC003;
    if (a == 16'h0013) r = 16'hD004;
    if (a == 16'hFFFF) r = 16'h1234;
    if (a == 16'h0000) r = 16'h5678;
    if (a >= 16'h0020 && a <= 16'h0027) r = 16'h2000 + a;
    return r;
  endfunction

  // Launch a transfer and wait (bounded) for done. edges = posedges from the
  // start-sampling edge to the edge that raised done; -1 on timeout.
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic fm,
                          input logic [15:0] fv, output int edges,
                          output int writes, output logic saw_busy,
                          output logic [15:0] first_addr,
                          output logic [15:0] wd);
    int base;
    @(negedge clock);
    src_addr = s; dst_addr = d; length = l; fill_mode = fm; fill_value = fv;
    start = 1'b1;
    base = wcount;
    edges = -1; saw_busy = 1'b0; first_addr = 16'h0000; wd = 16'h0000;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (n == 1) first_addr = mem_address;
      if (busy) saw_busy = 1'b1;
      if (done) begin
        edges = n - 1;
        wd = words_done;
        break;
      end
    end
    writes = wcount - base;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = 16'h0000; dst_addr = 16'h0000;
    length = 16'h0000; fill_mode = 1'b0; fill_value = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] <= orig(16'(i));
    repeat (2) @(negedge clock);
    vectors++;
    if ({busy, done, mem_write_enable, mem_address, mem_write_data, words_done} !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h wdata=%h wd=%h, expected all zero",
               busy, done, mem_write_enable, mem_address, mem_write_data, words_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_copy();
    int e, w; logic sb; logic [15:0] fa, wd;
    run_xfer(16'h0010, 16'h0100, 16'd4, 1'b0, 16'h0000, e, w, sb, fa, wd);
    vectors++;
    if (e !== 8) begin miscompares++; $display("FAIL copy_latency: got %0d expected 8", e); end
    vectors++;
    if (w !== 4) begin miscompares++; $display("FAIL copy_writes: got %0d expected 4", w); end
    vectors++;
    if (wd !== 16'd4) begin miscompares++; $display("FAIL copy_words_done: got %0d expected 4", wd); end
    vectors++;
    if (fa !== 16'h0010) begin miscompares++; $display("FAIL copy_first_addr: got %h expected 0010", fa); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[16'h0100 + 16'(i)] !== orig(16'h0010 + 16'(i))) begin
        miscompares++;
        $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[16'h0100 + 16'(i)], orig(16'h0010 + 16'(i)));
      end
    end
    vectors++;
    if (mem[16'h0104] !== orig(16'h0104)) begin
      miscompares++; $display("FAIL copy_overrun: got %h expected %h", mem[16'h0104], orig(16'h0104));
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL copy_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_zero_len();
    int e, w; logic sb; logic [15:0] fa, wd;
    run_xfer(16'h0010, 16'h0180, 16'd0, 1'b0, 16'h0000, e, w, sb, fa, wd);
    vectors++;
    if (e !== 0) begin miscompares++; $display("FAIL zero_latency: got %0d expected 0", e); end
    vectors++;
    if (w !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", w); end
    vectors++;
    if (sb !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", sb); end
    vectors++;
    if (wd !== 16'd0) begin miscompares++; $display("FAIL zero_words_done: got %0d expected 0", wd); end
  endtask

  task automatic test_wrap();
    int e, w; logic sb; logic [15:0] fa, wd;
    run_xfer(16'hFFFF, 16'h0200, 16'd2, 1'b0, 16'h0000, e, w, sb, fa, wd);
    vectors++;
    if (fa !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_first_addr: got %h expected ffff", fa); end
    vectors++;
    if (e !== 4) begin miscompares++; $display("FAIL wrap_latency: got %0d expected 4", e); end
    vectors++;
    if (mem[16'h0200] !== 16'h1234) begin miscompares++; $display("FAIL wrap_data0: got %h expected 1234", mem[16'h0200]); end
    vectors++;
    if (mem[16'h0201] !== 16'h5678) begin miscompares++; $display("FAIL wrap_data1: got %h expected 5678", mem[16'h0201]); end
  endtask

  task automatic test_start_ignored();
    int base, e, w; logic [15:0] wd;
    @(negedge clock);
    src_addr = 16'h0010; dst_addr = 16'h0500; length = 16'd4; fill_mode = 1'b0;
    start = 1'b1; base = wcount; e = -1; wd = 16'h0000;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      start = (n == 3);
      if (n == 3) begin src_addr = 16'h0020; dst_addr = 16'h0600; length = 16'd2; end
      if (done) begin e = n - 1; wd = words_done; break; end
    end
    w = wcount - base;
    vectors++;
    if (e !== 8) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 8", e); end
    vectors++;
    if (w !== 4) begin miscompares++; $display("FAIL ignore_writes: got %0d expected 4", w); end
    vectors++;
    if (wd !== 16'd4) begin miscompares++; $display("FAIL ignore_words_done: got %0d expected 4", wd); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[16'h0500 + 16'(i)] !== orig(16'h0010 + 16'(i))) begin
        miscompares++;
        $display("FAIL ignore_data[%0d]: got %h expected %h", i, mem[16'h0500 + 16'(i)], orig(16'h0010 + 16'(i)));
      end
    end
    vectors++;
    if (mem[16'h0600] !== orig(16'h0600)) begin
      miscompares++; $display("FAIL ignore_second_dst: got %h expected %h", mem[16'h0600], orig(16'h0600));
    end
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_fill();
    int e, w; logic sb; logic [15:0] fa, wd;
`ifdef DMA_COPY_ENGINE_FILL_EN
    run_xfer(16'h0010, 16'h0300, 16'd3, 1'b1, 16'hBEEF, e, w, sb, fa, wd);
    vectors++;
    if (e !== 3) begin miscompares++; $display("FAIL fill_latency: got %0d expected 3", e); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem[16'h0300 + 16'(i)] !== 16'hBEEF) begin
        miscompares++; $display("FAIL fill_data[%0d]: got %h expected beef", i, mem[16'h0300 + 16'(i)]);
      end
    end
`else
    run_xfer(16'h0010, 16'h0300, 16'd3, 1'b1, 16'hBEEF, e, w, sb, fa, wd);
    vectors++;
    if (e !== 6) begin miscompares++; $display("FAIL nofill_latency: got %0d expected 6", e); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem[16'h0300 + 16'(i)] !== orig(16'h0010 + 16'(i))) begin
        miscompares++;
        $display("FAIL nofill_data[%0d]: got %h expected %h", i, mem[16'h0300 + 16'(i)], orig(16'h0010 + 16'(i)));
      end
    end
`endif
    vectors++;
    if (w !== 3) begin miscompares++; $display("FAIL fill_writes: got %0d expected 3", w); end
    vectors++;
    if (mem[16'h0303] !== orig(16'h0303)) begin
      miscompares++; $display("FAIL fill_overrun: got %h expected %h", mem[16'h0303], orig(16'h0303));
    end
  endtask

  task automatic test_abort();
    int base, n, changed;
    @(negedge clock);
    src_addr = 16'h0020; dst_addr = 16'h0400; length = 16'd8; fill_mode = 1'b0;
    start = 1'b1; base = wcount; n = 0;
    while ((wcount - base) < 3 && n < 100) begin
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    vectors++;
    if ((wcount - base) !== 3) begin miscompares++; $display("FAIL abort_wait: got %0d writes expected 3", wcount - base); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, mem_write_enable, mem_address, mem_write_data, words_done} !== 51'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%b done=%b we=%b addr=%h wdata=%h wd=%h, expected all zero",
               busy, done, mem_write_enable, mem_address, mem_write_data, words_done);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    changed = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem[16'h0400 + 16'(i)] !== orig(16'h0400 + 16'(i))) changed++;
    end
    vectors++;
    if (changed !== 3) begin miscompares++; $display("FAIL abort_changed: got %0d expected 3", changed); end
    vectors++;
    if (mem[16'h0402] !== orig(16'h0022)) begin
      miscompares++; $display("FAIL abort_data2: got %h expected %h", mem[16'h0402], orig(16'h0022));
    end
  endtask

  task automatic test_back_to_back();
    int e, w; logic sb; logic [15:0] fa, wd;
    run_xfer(16'h0013, 16'h0700, 16'd1, 1'b0, 16'h0000, e, w, sb, fa, wd);
    vectors++;
    if (e !== 2) begin miscompares++; $display("FAIL single_latency: got %0d expected 2", e); end
    vectors++;
    if (mem[16'h0700] !== 16'hD004) begin miscompares++; $display("FAIL single_data: got %h expected d004", mem[16'h0700]); end
    run_xfer(16'h0011, 16'h0710, 16'd2, 1'b0, 16'h0000, e, w, sb, fa, wd);
    vectors++;
    if (e !== 4) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 4", e); end
    vectors++;
    if ({mem[16'h0710], mem[16'h0711]} !== {16'hB002, 16'hC003}) begin
      miscompares++; $display("FAIL b2b_data: got %h %h expected b002 c003", mem[16'h0710], mem[16'h0711]);
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zero_len();
    test_wrap();
    test_start_ignored();
    test_fill();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
